// File: rtl/spi_ram_burst.sv
// Command RAM behind the SPI slave path: opcode-driven address set / write / read with burst auto-increment.
// Latency: a READ accepted at edge N presents dout/tx_valid from edge N onward (one-cycle read).
// Backpressure: a single-entry output register; rx_ready drops while the result is held and tx_ready is low.
module spi_ram_burst #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256,
  parameter int AUTO_INC  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W+1:0] din,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [DATA_W-1:0] dout,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              err
);

  localparam logic [1:0] OP_SET_WADDR = 2'b00;
  localparam logic [1:0] OP_WRITE     = 2'b01;
  localparam logic [1:0] OP_SET_RADDR = 2'b10;
  localparam logic [1:0] OP_READ      = 2'b11;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  // Depth needs one bit more than an address to hold 2**ADDR_W.
  localparam logic [ADDR_W:0]   LP_DEPTH = (ADDR_W+1)'(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(MEM_DEPTH - 1);
  localparam int                IDX_W    = $clog2(MEM_DEPTH);

  logic [DATA_W-1:0] r_mem [MEM_DEPTH];
  logic [ADDR_W-1:0] r_waddr;
  logic [ADDR_W-1:0] r_raddr;
  logic [DATA_W-1:0] r_dout;
  logic [0:0]        r_state;
  logic              r_err;

  logic [1:0]        w_op;
  logic [DATA_W-1:0] w_payload;
  logic [ADDR_W-1:0] w_addr_arg;
  logic              w_in_range;
  logic              w_accept;
  logic [IDX_W-1:0]  w_widx;
  logic [IDX_W-1:0]  w_ridx;

  // Pointer advance after WRITE/READ; wraps at the last word so a pointer never reaches MEM_DEPTH.
  function automatic logic [ADDR_W-1:0] f_next(input logic [ADDR_W-1:0] p);
    if (AUTO_INC == 0) return p;
    return (p == LP_LAST) ? '0 : p + ADDR_W'(1);
  endfunction

  assign w_op       = din[DATA_W+1:DATA_W];
  assign w_payload  = din[DATA_W-1:0];
  assign w_addr_arg = din[ADDR_W-1:0];
  assign w_in_range = ({1'b0, w_addr_arg} < LP_DEPTH);
  assign tx_valid   = (r_state == ST_FULL);
  assign rx_ready   = !tx_valid || tx_ready;
  assign w_accept   = rx_valid && rx_ready;
  assign dout       = r_dout;
  assign err        = r_err;
  // Pointers are always kept below MEM_DEPTH, so the low bits are a complete array index.
  assign w_widx     = r_waddr[IDX_W-1:0];
  assign w_ridx     = r_raddr[IDX_W-1:0];

  // Memory array write port; deliberately unreset so contents survive rst.
  always_ff @(posedge clk) begin
    if (!rst && w_accept && (w_op == OP_WRITE)) begin
      r_mem[w_widx] <= w_payload;
    end
  end

  // Address pointers and sticky range-error flag, updated by accepted commands.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_waddr <= '0;
      r_raddr <= '0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      case (w_op)
        OP_SET_WADDR: begin
          if (w_in_range) r_waddr <= w_addr_arg;
          else            r_err   <= 1'b1;
        end
        OP_WRITE:     r_waddr <= f_next(r_waddr);
        OP_SET_RADDR: begin
          if (w_in_range) r_raddr <= w_addr_arg;
          else            r_err   <= 1'b1;
        end
        default:      r_raddr <= f_next(r_raddr);
      endcase
    end
  end

  // Output stage EMPTY/FULL: a new READ reloads dout; otherwise tx_ready drains it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
      r_dout  <= '0;
    end else if (w_accept && (w_op == OP_READ)) begin
      r_state <= ST_FULL;
      r_dout  <= r_mem[w_ridx];
    end else if (tx_ready) begin
      r_state <= ST_EMPTY;
    end
  end

endmodule

// File: doc/spi_ram_burst.md
# spi_ram_burst

Parametrised single-port command RAM behind the SPI slave receive/transmit path, successor to the fixed 8-bit command RAM. Consumes 2-bit-opcode command words from the SPI deserialiser, supports arbitrary data width and non-power-of-two depth, and auto-increments addresses for burst transfers. Read data leaves through a valid/ready handshake with back-pressure, so no read result is lost when the SPI transmitter is busy.

## Interface

Parameters:
- DATA_W, 8: memory word and payload width.
- ADDR_W, 8: address width; ADDR_W <= DATA_W is required.
- MEM_DEPTH, 256: number of words; must satisfy 2 <= MEM_DEPTH <= 2**ADDR_W.
- AUTO_INC, 1: 1 = post-increment the address after each WRITE/READ; 0 = address static.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- din  in  DATA_W+2  command word; [DATA_W+1:DATA_W] opcode, [DATA_W-1:0] payload.
- rx_valid  in  1  din valid.
- rx_ready  out  1  command can be accepted this cycle.
- dout  out  DATA_W  read data.
- tx_valid  out  1  dout valid; held until accepted.
- tx_ready  in  1  downstream accepts dout.
- err  out  1  sticky out-of-range address flag.

## Operation

- Command accepted on a cycle with rx_valid && rx_ready; otherwise din is ignored.
- Opcodes:
  - 00 SET_WADDR: if din[ADDR_W-1:0] < MEM_DEPTH, waddr <= it; else waddr unchanged, err <= 1.
  - 01 WRITE: mem[waddr] <= din[DATA_W-1:0]; if AUTO_INC, waddr <= (waddr == MEM_DEPTH-1) ? 0 : waddr+1.
  - 10 SET_RADDR: same rules as SET_WADDR on raddr. Does not assert tx_valid.
  - 11 READ: dout <= mem[raddr], tx_valid <= 1; raddr post-increments and wraps identically to waddr.
- Payload bits [DATA_W-1:ADDR_W] are ignored for SET_*ADDR.
- Output stage is a two-state FSM:
  - EMPTY (tx_valid=0) -> FULL on an accepted READ.
  - FULL -> EMPTY when tx_ready=1 and no READ is accepted in the same cycle.
  - FULL -> FULL with new dout when tx_ready=1 and a READ is accepted in the same cycle.
- rx_ready = !tx_valid || tx_ready, combinational. While FULL and tx_ready=0, no command of any opcode is accepted; upstream holds din.
- err is cleared only by rst.
- Memory array is not reset; contents survive rst. Reading a never-written word returns undefined data.

## Timing

- Reset values (cycle after rst sampled high): dout=0, tx_valid=0, err=0, waddr=0, raddr=0. rx_ready=1 follows.
- rst dominates: an asserted rst discards any pending tx_valid and ignores rx_valid in that cycle. A WRITE presented with rst does not modify memory.
- READ latency: accepted at edge N; dout/tx_valid valid after edge N (visible cycle N+1).
- Sustained throughput: one command per cycle while tx_ready=1.
- Read-after-write: WRITE to A at edge N, READ of A accepted at edge N+1 returns the new data.
- Wrap: READ/WRITE at MEM_DEPTH-1 with AUTO_INC=1 sets the pointer to 0, never to MEM_DEPTH.
- dout is stable while tx_valid=1 and tx_ready=0.

## Test plan

- Reset/basic: rst 2 cycles; SET_WADDR 0x10, WRITE 0xA5, SET_RADDR 0x10, READ -> dout=0xA5, tx_valid=1 one cycle after READ; err=0.
- Burst: SET_WADDR 0xFE, WRITE 0x11, 0x22, 0x33 -> mem[0xFE]=0x11, mem[0xFF]=0x22, mem[0x00]=0x33; SET_RADDR 0xFE, three READs with tx_ready=1 -> 0x11, 0x22, 0x33 on consecutive cycles.
- Back-pressure: READ with tx_ready=0 -> tx_valid=1, rx_ready=0. Hold a second READ 5 cycles -> dout unchanged, raddr unchanged. Raise tx_ready -> second READ accepted the same cycle, next dout = next word.
- Range error, MEM_DEPTH=200: SET_WADDR 0xC8 -> err=1, waddr unchanged (WRITE 0x5A lands at prior waddr). SET_WADDR 0xC7, WRITE, WRITE -> second write at address 0.
- Mid-operation reset: tx_valid=1 and tx_ready=0, assert rst 1 cycle -> tx_valid=0, dout=0, err=0. Prior written data is still readable after SET_RADDR/READ.
- AUTO_INC=0, DATA_W=16, ADDR_W=8: SET_WADDR 0xFF05, WRITE 0xBEEF twice, READ at 0x05 twice -> both return 0xBEEF, pointers remain 0x05.
